// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: source encodings and the queued
// {rob id, value} entry width.
package cdb_arbiter_pkg;

    localparam logic SRC_ALU  = 1'b0;
    localparam logic SRC_LOAD = 1'b1;

    localparam int VALUE_WIDTH = 32;

    function automatic int entry_width(input int rob_width);
        return rob_width + VALUE_WIDTH;
    endfunction

endpackage

// File: rtl/result_queue.sv
// Small per-source result FIFO holding {rob id, value}; depth 2**QUEUE_WIDTH,
// registered full/empty so stall has no combinational path from the inputs.
module result_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH   = 4,
    parameter int QUEUE_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clear,
    input  logic [ROB_WIDTH+VALUE_WIDTH-1:0] entry,
    output logic [ROB_WIDTH+VALUE_WIDTH-1:0] head,
    output logic                             empty,
    output logic                             full
);

    localparam int ENTRY_W = entry_width(ROB_WIDTH);
    localparam int DEPTH   = 2 ** QUEUE_WIDTH;
    localparam logic [QUEUE_WIDTH:0] FULL_COUNT = {1'b1, {QUEUE_WIDTH{1'b0}}};

    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [QUEUE_WIDTH-1:0] rd_ptr;
    logic [QUEUE_WIDTH-1:0] wr_ptr;
    logic [QUEUE_WIDTH:0]   count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is data only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the ALU and load result queues (with bypass)
// into a single registered common-data-bus broadcast slot.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH   = 4,
    parameter int QUEUE_WIDTH = 1
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 clear,
    input  logic                 aluFlag,
    input  logic [ROB_WIDTH-1:0] aluId,
    input  logic [31:0]          aluValue,
    output logic                 aluStall,
    input  logic                 loadFlag,
    input  logic [ROB_WIDTH-1:0] loadId,
    input  logic [31:0]          loadValue,
    output logic                 loadStall,
    output logic                 cdbFlag,
    output logic [ROB_WIDTH-1:0] cdbId,
    output logic [31:0]          cdbValue,
    output logic                 cdbSrc
);

    localparam int ENTRY_W = entry_width(ROB_WIDTH);

    logic               enable;
    logic               flush;
    logic [ENTRY_W-1:0] alu_in_entry;
    logic [ENTRY_W-1:0] load_in_entry;
    logic [ENTRY_W-1:0] alu_head;
    logic [ENTRY_W-1:0] load_head;
    logic               alu_empty;
    logic               alu_full;
    logic               load_empty;
    logic               load_full;
    logic               alu_accept;
    logic               load_accept;
    logic               alu_cand;
    logic               load_cand;
    logic               alu_push;
    logic               alu_pop;
    logic               load_push;
    logic               load_pop;
    logic               last_grant;
    logic               grant_valid;
    logic               grant_src;
    logic [ENTRY_W-1:0] grant_entry;

    assign enable = readyIn & ~clear;
    assign flush  = readyIn & clear;

    assign alu_in_entry  = {aluId, aluValue};
    assign load_in_entry = {loadId, loadValue};

    // An incoming flag is dropped while its queue is full.
    assign alu_accept  = enable & aluFlag  & ~alu_full;
    assign load_accept = enable & loadFlag & ~load_full;

    assign alu_cand  = enable & (~alu_empty  | alu_accept);
    assign load_cand = enable & (~load_empty | load_accept);

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_ALU;
        grant_entry = '0;
        if (alu_cand && load_cand) begin
            grant_valid = 1'b1;
            grant_src   = ~last_grant;
        end else if (alu_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ALU;
        end else if (load_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LOAD;
        end
        if (grant_src == SRC_ALU)
            grant_entry = alu_empty ? alu_in_entry : alu_head;
        else
            grant_entry = load_empty ? load_in_entry : load_head;
    end

    // A granted queue head pops; a bypass grant consumes the input without enqueuing it.
    assign alu_pop   = grant_valid & (grant_src == SRC_ALU)  & ~alu_empty;
    assign load_pop  = grant_valid & (grant_src == SRC_LOAD) & ~load_empty;
    assign alu_push  = alu_accept  & ~(grant_valid & (grant_src == SRC_ALU)  & alu_empty);
    assign load_push = load_accept & ~(grant_valid & (grant_src == SRC_LOAD) & load_empty);

    result_queue #(
        .ROB_WIDTH  (ROB_WIDTH),
        .QUEUE_WIDTH(QUEUE_WIDTH)
    ) u_alu_queue (
        .clk  (clockIn),
        .rst  (resetIn),
        .push (alu_push),
        .pop  (alu_pop),
        .clear(flush),
        .entry(alu_in_entry),
        .head (alu_head),
        .empty(alu_empty),
        .full (alu_full)
    );

    result_queue #(
        .ROB_WIDTH  (ROB_WIDTH),
        .QUEUE_WIDTH(QUEUE_WIDTH)
    ) u_load_queue (
        .clk  (clockIn),
        .rst  (resetIn),
        .push (load_push),
        .pop  (load_pop),
        .clear(flush),
        .entry(load_in_entry),
        .head (load_head),
        .empty(load_empty),
        .full (load_full)
    );

    assign aluStall  = alu_full;
    assign loadStall = load_full;

    // Broadcast slot: id/value/src hold across idle cycles, only cdbFlag drops.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            cdbFlag    <= 1'b0;
            cdbId      <= '0;
            cdbValue   <= '0;
            cdbSrc     <= SRC_ALU;
            last_grant <= SRC_LOAD;
        end else if (flush) begin
            cdbFlag    <= 1'b0;
            last_grant <= SRC_LOAD;
        end else if (readyIn) begin
            if (grant_valid) begin
                cdbFlag    <= 1'b1;
                cdbId      <= grant_entry[ENTRY_W-1 -: ROB_WIDTH];
                cdbValue   <= grant_entry[VALUE_WIDTH-1:0];
                cdbSrc     <= grant_src;
                last_grant <= grant_src;
            end else begin
                cdbFlag <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single result broadcast bus (CDB) between the ALU reservation station and the load/store buffer's load path. Each source gets a small result queue with backpressure. A round-robin arbiter drains the queues into one registered broadcast slot. That slot feeds the reorder buffer's single result port and the operand-forwarding logic, so a load and an ALU result finishing in the same cycle is never lost.

## Interface
Parameters:
- ROB_WIDTH, 4, width of a ROB entry id
- QUEUE_WIDTH, 1, log2 of per-source queue depth (depth 2)

Ports:
- clockIn  input  1  clock; all state updates on posedge
- resetIn  input  1  synchronous, active-high reset
- readyIn  input  1  global clock enable; low = hold all state, ignore inputs
- clear  input  1  mispredict flush; acts only when readyIn high
- aluFlag  input  1  ALU result valid
- aluId  input  ROB_WIDTH  ROB id of ALU result
- aluValue  input  32  ALU result
- aluStall  output  1  ALU queue full; ALU must not assert aluFlag
- loadFlag  input  1  load result valid
- loadId  input  ROB_WIDTH  ROB id of load result
- loadValue  input  32  load data
- loadStall  output  1  load queue full
- cdbFlag  output  1  broadcast valid (one cycle per result)
- cdbId  output  ROB_WIDTH  broadcast ROB id
- cdbValue  output  32  broadcast value
- cdbSrc  output  1  0 = ALU, 1 = load

## Operation
- Per source, a FIFO of depth 2^QUEUE_WIDTH stores {id, value}.
  - Count is QUEUE_WIDTH+1 bits.
  - Read and write pointers wrap modulo depth.
- Stall is registered-state-derived: stall = (count == depth). It has no combinational path from the flag inputs.
- A flag asserted while the matching stall is high is dropped: no enqueue, no broadcast.
- Candidate per source each cycle:
  - the queue head if the queue is non-empty;
  - otherwise the incoming flag/id/value (bypass).
- Arbitration:
  - One candidate: grant it.
  - Two candidates: grant the source that is not lastGrant.
  - lastGrant updates to the granted source on every grant.
- The granted candidate loads cdbId/cdbValue/cdbSrc, with cdbFlag = 1.
  - If the grant came from the queue, that queue pops.
  - If it came from bypass, nothing is enqueued.
- A non-granted incoming flag is enqueued.
  - This includes the case where its queue head was granted: simultaneous pop and push keeps the count unchanged.
- No candidate: cdbFlag <= 0; id/value/src hold their last values.
- Every accepted result is broadcast exactly once, in per-source arrival order.

## Timing
- Reset values:
  - cdbFlag = 0, cdbId = 0, cdbValue = 0, cdbSrc = 0
  - aluStall = 0, loadStall = 0
  - both queues empty, lastGrant = 1 (first tie goes to ALU)
- Latency:
  - A result sampled at edge N with its queue empty and granted is visible on the CDB during the cycle after edge N.
  - A queued result appears one cycle after the edge at which it is granted.
- Stall rises the cycle after the edge that fills the queue. It falls the cycle after the edge that pops it.
- clear & readyIn at edge N:
  - both queues flush, cdbFlag <= 0, lastGrant <= 1
  - inputs sampled at edge N are discarded
  - the stalls read 0 after edge N
- resetIn has priority over clear and readyIn.
- readyIn low: no push, no pop, no arbitration. Outputs hold, including cdbFlag, so a broadcast persists until the next enabled edge.
- Sustained full-rate input from both sources:
  - CDB throughput is 1 per cycle.
  - The queues fill, stall throttles the sources, and grants alternate strictly.

## Structure
- Shared package holds SRC_ALU = 1'b0, SRC_LOAD = 1'b1, and the {id, value} result entry width (ROB_WIDTH+32).
- Sub-module result_queue (parameters ROB_WIDTH and QUEUE_WIDTH):
  - inputs: push, pop, clear, entry
  - outputs: head entry, empty, full
  - instantiated twice
- Arbitration, bypass select and the output register live in cdb_arbiter.

## Test plan
- Reset, then ALU-only aluFlag, id=3, value=0x11 → next cycle cdbFlag=1, cdbId=3, cdbValue=0x11, cdbSrc=0; following cycle cdbFlag=0.
- ALU (id=1, 0xA) and load (id=2, 0xB) on the same edge after reset → cycle+1: ALU id 1; cycle+2: load id 2; no loss.
- Both sources every cycle for 10 cycles, ids incrementing → strict alternation on cdbSrc; each stall asserts when its queue holds 2; every id broadcast once, in order per source.
- Fill the load queue (2 entries), assert loadFlag with loadStall=1 (id=7) → id 7 never broadcast.
- Queue 2 ALU entries, pulse clear with readyIn=1 → cdbFlag=0 next cycle; no queued id ever appears; aluStall=0.
- Hold readyIn=0 for 3 cycles with a pending broadcast and aluFlag high → CDB outputs and queue counts frozen; resume with the next broadcast on the first enabled edge.
